spi_master_multi: RTL and testbench
===================================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the bits per word (legal 4..32).
REQ-002 Parameter NUM_CS, default 2, SHALL set the number of chip-select outputs (legal 1..8).
REQ-003 Parameter DIV_W, default 8, SHALL set the width of the clock-divider input.
REQ-004 clk  in  1  SHALL be the single clock; every register SHALL be clocked on its rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 start  in  1  SHALL request one word transfer; it is sampled only while ready=1.
REQ-007 tx_data  in  DATA_W  SHALL carry the word to send, MSB first.
REQ-008 cs_sel  in  max(1,clog2(NUM_CS))  SHALL select the target slave.
REQ-009 cpol, cpha  in  1 each  SHALL select the SPI mode.
REQ-010 div  in  DIV_W  SHALL set the SCLK half-period to H=div+1 clk cycles.
REQ-011 hold_cs  in  1  SHALL request that CS stay asserted after the word completes (burst).
REQ-012 release  in  1  SHALL end a held burst.
REQ-013 ready  out  1  SHALL be high when start can be accepted.
REQ-014 rx_data  out  DATA_W  SHALL present the last received word.
REQ-015 rx_valid  out  1  SHALL be a one-cycle strobe marking a new rx_data.
REQ-016 sclk, mosi  out  1 each; miso  in  1; cs_n  out  NUM_CS, active low.

Function
REQ-017 FSM states SHALL be IDLE, LEAD, XFER, HOLD and TRAIL.
REQ-018 IDLE: ready=1; all cs_n=1; sclk<=cpol input every cycle.
REQ-019 IDLE and start=1 with cs_sel<NUM_CS: latch tx_data, cs_sel, cpol, cpha, div and hold_cs; drive cs_n[cs_sel]=0; go to LEAD.
REQ-020 IDLE and start=1 with cs_sel>=NUM_CS: the request SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-021 LEAD SHALL last H cycles; with cpha=0, mosi SHALL hold the MSB from LEAD entry; exit to XFER.
REQ-022 XFER SHALL make 2*DATA_W sclk toggles, one every H cycles, starting H cycles after XFER entry.
REQ-023 Leading edges are odd toggles; with cpha=0, sample miso on leading edges and shift mosi on trailing edges.
REQ-024 With cpha=1, shift mosi on leading edges and sample miso on trailing edges.
REQ-025 Received bits SHALL shift in MSB first.
REQ-026 After the final toggle, rx_data SHALL update and rx_valid SHALL pulse for exactly 1 cycle, the cycle the FSM leaves XFER.
REQ-027 On leaving XFER, go to HOLD if the latched hold_cs=1, otherwise to TRAIL.
REQ-028 HOLD: ready=1; cs_n unchanged; sclk at the latched cpol.
REQ-029 HOLD and start=1: latch tx_data and hold_cs only (cs_sel, cpol, cpha and div retained); go directly to XFER.
REQ-030 HOLD and release=1 with start=0: go to TRAIL.
REQ-031 HOLD with start=1 and release=1 together: start SHALL win.
REQ-032 TRAIL SHALL last H cycles, then drive all cs_n=1 and go to IDLE.
REQ-033 Single-word latency: CS asserted for H*(2*DATA_W+2) cycles, start-accept to IDLE.
REQ-034 ready SHALL be 0 in LEAD, XFER and TRAIL, and start SHALL be ignored in those states.
REQ-035 Input changes other than miso, start and release SHALL have no effect mid-transfer.
REQ-036 div=0 SHALL give sclk=clk/2; div=2^DIV_W-1 SHALL not overflow the half-period counter.
REQ-037 At most one cs_n bit SHALL be low at any time.

Reset
REQ-038 While reset=1 at a rising edge: state=IDLE, all cs_n=1, sclk=0, mosi=0, rx_data=0, rx_valid=0, all latches and counters 0.
REQ-039 ready SHALL read 1 in the cycle after reset.
REQ-040 Reset mid-transfer SHALL abort the transfer with no rx_valid pulse and a CS release in the next cycle.

Verification
REQ-041 Mode 0, div=0, cs_sel=0, tx=0xA5, miso looped from mosi -> cs_n=2'b10 for 18 cycles; 8 rising sclk edges; rx_data=0xA5; one rx_valid pulse.
REQ-042 Mode 3, div=3, cs_sel=1, tx=0x3C, miso=1 -> sclk idles high; half-period 4 cycles; cs_n=2'b01; rx_data=0xFF.
REQ-043 hold_cs=1, words 0x01 then 0x80, then release -> cs_n[0] stays low throughout; 2 rx_valid pulses; CS released H cycles after release.
REQ-044 Reset asserted after 5 sclk toggles -> next cycle: cs_n=2'b11, sclk=0, rx_valid=0; ready=1 the cycle after.
REQ-045 start with cs_sel=2, and start pulsed during XFER -> both ignored; no cs_n change; no extra transfer.
REQ-046 In HOLD, start and release in the same cycle -> a second word is sent and CS stays low.

Source files
------------

// File: rtl/spi_master_multi.sv
// -----------------------------------------------------------------------------
// spi_master_multi
//
// Single-word SPI master with NUM_CS chip selects, all four SPI modes, a
// programmable SCLK half-period and optional CS hold between words (burst).
//
// Ports
//   i_clk        single clock, all state on its rising edge
//   i_reset      synchronous active-high reset
//   i_start      request a word transfer (taken only while o_ready=1)
//   i_tx_data    word to send, MSB first
//   i_cs_sel     target slave index (values >= NUM_CS are ignored)
//   i_cpol       SCLK idle level
//   i_cpha       0: sample on leading edge, 1: sample on trailing edge
//   i_div        SCLK half-period H = i_div+1 clk cycles
//   i_hold_cs    keep CS asserted after the word (burst)
//   i_release    end a held burst
//   o_ready      start can be accepted (IDLE or HOLD)
//   o_rx_data    last received word
//   o_rx_valid   one-cycle strobe marking a new o_rx_data
//   o_sclk       SPI clock
//   o_mosi       serial data out
//   i_miso       serial data in
//   o_cs_n       active-low chip selects, at most one low
// -----------------------------------------------------------------------------
module spi_master_multi #(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 2,
   parameter int DIV_W  = 8,
   localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic [SEL_W-1:0]  i_cs_sel,
   input  logic              i_cpol,
   input  logic              i_cpha,
   input  logic [DIV_W-1:0]  i_div,
   input  logic              i_hold_cs,
   input  logic              i_release,
   output logic              o_ready,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   output logic              o_sclk,
   output logic              o_mosi,
   input  logic              i_miso,
   output logic [NUM_CS-1:0] o_cs_n
);

   localparam int TOG_W = $clog2(2 * DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_XFER,
      S_HOLD,
      S_TRAIL
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_ready;

   logic [NUM_CS-1:0]   r_cs_n;
   logic                r_sclk;
   logic                r_mosi;
   logic [DATA_W-1:0]   r_rx_data;
   logic                r_rx_valid;
   logic [DATA_W-1:0]   r_tx;
   logic [DATA_W-1:0]   r_rx;
   logic                r_cpol;
   logic                r_cpha;
   logic [DIV_W-1:0]    r_div;
   logic                r_hold;
   logic [DIV_W-1:0]    r_cnt;
   logic [TOG_W-1:0]    r_tog;

   logic                w_sel_ok;
   logic                w_accept;
   logic                w_tick;
   logic                w_last;
   logic                w_lead;
   logic [DATA_W-1:0]   w_rx_shift;

   assign w_sel_ok   = (32'(i_cs_sel) < NUM_CS);
   assign w_accept   = (r_state == S_IDLE) && i_start && w_sel_ok;
   // The half-period counter only ever counts up to r_div, so it can never
   // wrap even when div is at its maximum value.
   assign w_tick     = (r_cnt == r_div);
   assign w_last     = w_tick && (r_tog == TOG_W'(2 * DATA_W - 1));
   // r_tog holds the number of toggles already made; the next one is a
   // leading (odd-numbered) edge when that count is even.
   assign w_lead     = ~r_tog[0];
   assign w_rx_shift = {r_rx[DATA_W-2:0], i_miso};

   assign o_ready    = w_ready;
   assign o_rx_data  = r_rx_data;
   assign o_rx_valid = r_rx_valid;
   assign o_sclk     = r_sclk;
   assign o_mosi     = r_mosi;
   assign o_cs_n     = r_cs_n;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and ready decode
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (w_accept) begin
               w_state_nxt = S_LEAD;
            end
         end
         S_LEAD: begin
            if (w_tick) begin
               w_state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            if (w_last) begin
               w_state_nxt = r_hold ? S_HOLD : S_TRAIL;
            end
         end
         S_HOLD: begin
            w_ready = 1'b1;
            // start takes priority over release
            if (i_start) begin
               w_state_nxt = S_XFER;
            end else if (i_release) begin
               w_state_nxt = S_TRAIL;
            end
         end
         S_TRAIL: begin
            if (w_tick) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: shift registers, counters, SPI pins
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cs_n     <= '1;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_div      <= '0;
         r_hold     <= 1'b0;
         r_cnt      <= '0;
         r_tog      <= '0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_sclk <= i_cpol;
               r_cnt  <= '0;
               r_tog  <= '0;
               if (w_accept) begin
                  r_cpol <= i_cpol;
                  r_cpha <= i_cpha;
                  r_div  <= i_div;
                  r_hold <= i_hold_cs;
                  r_cs_n <= ~(NUM_CS'(1) << i_cs_sel);
                  // With cpha=0 the MSB must be on the line before the first
                  // edge; with cpha=1 the first leading edge puts it out.
                  if (!i_cpha) begin
                     r_mosi <= i_tx_data[DATA_W-1];
                     r_tx   <= i_tx_data << 1;
                  end else begin
                     r_tx   <= i_tx_data;
                  end
               end
            end
            S_LEAD: begin
               r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
            end
            S_XFER: begin
               if (w_tick) begin
                  r_cnt  <= '0;
                  r_sclk <= ~r_sclk;
                  r_tog  <= r_tog + TOG_W'(1);
                  // Shift edge: trailing for cpha=0, leading for cpha=1.
                  if (w_lead == r_cpha) begin
                     r_mosi <= r_tx[DATA_W-1];
                     r_tx   <= r_tx << 1;
                  end else begin
                     r_rx   <= w_rx_shift;
                  end
                  // The final toggle is always a trailing edge: for cpha=1 it
                  // also carries the last sample, for cpha=0 r_rx is complete.
                  if (w_last) begin
                     r_rx_valid <= 1'b1;
                     r_rx_data  <= r_cpha ? w_rx_shift : r_rx;
                  end
               end else begin
                  r_cnt <= r_cnt + DIV_W'(1);
               end
            end
            S_HOLD: begin
               r_sclk <= r_cpol;
               r_cnt  <= '0;
               r_tog  <= '0;
               if (i_start) begin
                  r_hold <= i_hold_cs;
                  if (!r_cpha) begin
                     r_mosi <= i_tx_data[DATA_W-1];
                     r_tx   <= i_tx_data << 1;
                  end else begin
                     r_tx   <= i_tx_data;
                  end
               end
            end
            S_TRAIL: begin
               if (w_tick) begin
                  r_cnt  <= '0;
                  r_cs_n <= '1;
               end else begin
                  r_cnt  <= r_cnt + DIV_W'(1);
               end
            end
            default: begin
               r_cs_n <= '1;
               r_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_multi.sv
// -----------------------------------------------------------------------------
// tb_spi_master_multi
//
// Directed bench for spi_master_multi. Received words are predicted into a
// queue when each transfer is started and popped when o_rx_valid fires.
// A second instance with NUM_CS=3 exercises an out-of-range chip select.
// -----------------------------------------------------------------------------
module tb_spi_master_multi;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] tx_data;
   logic       cs_sel;
   logic       cpol;
   logic       cpha;
   logic [7:0] div;
   logic       hold_cs;
   logic       rel;
   logic       ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic [1:0] cs_n;
   logic       loop_en;
   logic       miso_fix;

   logic       start3;
   logic [1:0] cs_sel3;
   logic       ready3;
   logic [7:0] rx_data3;
   logic       rx_valid3;
   logic       sclk3;
   logic       mosi3;
   logic [2:0] cs_n3;

   assign miso = loop_en ? mosi : miso_fix;

   always #5 clk = ~clk;

   spi_master_multi #(.DATA_W(8), .NUM_CS(2), .DIV_W(8)) u_dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_tx_data(tx_data),
      .i_cs_sel(cs_sel), .i_cpol(cpol), .i_cpha(cpha), .i_div(div),
      .i_hold_cs(hold_cs), .i_release(rel), .o_ready(ready),
      .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_sclk(sclk),
      .o_mosi(mosi), .i_miso(miso), .o_cs_n(cs_n)
   );

   spi_master_multi #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) u_dut3 (
      .i_clk(clk), .i_reset(reset), .i_start(start3), .i_tx_data(tx_data),
      .i_cs_sel(cs_sel3), .i_cpol(cpol), .i_cpha(cpha), .i_div(div),
      .i_hold_cs(hold_cs), .i_release(rel), .o_ready(ready3),
      .o_rx_data(rx_data3), .o_rx_valid(rx_valid3), .o_sclk(sclk3),
      .o_mosi(mosi3), .i_miso(miso_fix), .o_cs_n(cs_n3)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   int         cs_low_cnt, cs1_low_cnt, rise_cnt, rx_cnt, cs0_rel_cnt;
   int         onehot_viol = 0;
   logic       sclk_prev, cs0_prev;
   bit         mon_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      cs_low_cnt  = 0;
      cs1_low_cnt = 0;
      rise_cnt    = 0;
      rx_cnt      = 0;
      cs0_rel_cnt = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (ready === 1'b1 && cs_n === 2'b11) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_ready(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Bus monitor and scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (mon_en) begin
         if (cs_n !== 2'b11) cs_low_cnt++;
         if (cs_n[1] === 1'b0) cs1_low_cnt++;
         if (cs0_prev === 1'b0 && cs_n[0] === 1'b1) cs0_rel_cnt++;
         if (sclk_prev === 1'b0 && sclk === 1'b1) rise_cnt++;
         if (cs_n === 2'b00) onehot_viol++;
         sclk_prev = sclk;
         cs0_prev  = cs_n[0];
         if (rx_valid === 1'b1) begin
            rx_cnt++;
            check("rx_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("rx_data", rx_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         ok;
      int         ntog;
      logic       prev;
      logic [0:15] sc;

      reset = 1'b1; start = 1'b0; tx_data = '0; cs_sel = 1'b0; cpol = 1'b0;
      cpha = 1'b0; div = '0; hold_cs = 1'b0; rel = 1'b0; loop_en = 1'b0;
      miso_fix = 1'b0; start3 = 1'b0; cs_sel3 = '0;
      clear_counts();

      // ---- reset state
      repeat (3) tick();
      check("rst_cs_n", cs_n, 2'b11);
      check("rst_sclk", sclk, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_cs_n3", cs_n3, 3'b111);
      reset = 1'b0;
      sclk_prev = sclk;
      cs0_prev  = cs_n[0];
      mon_en    = 1'b1;
      tick();
      check("ready_after_reset", ready, 1'b1);

      // ---- mode 0, div=0, loopback 0xA5
      cpol = 1'b0; cpha = 1'b0; div = 8'd0; cs_sel = 1'b0; tx_data = 8'hA5;
      loop_en = 1'b1; hold_cs = 1'b0;
      clear_counts();
      exp_q.push_back(8'hA5);
      do_start();
      check("m0_cs_n", cs_n, 2'b10);
      check("m0_ready", ready, 1'b0);
      check("m0_mosi_msb", mosi, 1'b1);
      wait_idle(200, ok);
      check("m0_done", 32'(ok), 1);
      check("m0_cs_low_cycles", cs_low_cnt, 18);
      check("m0_sclk_rises", rise_cnt, 8);
      check("m0_rx_pulses", rx_cnt, 1);
      check("m0_rx_data", rx_data, 8'hA5);

      // ---- mode 3, div=3, cs 1, miso=1; inputs disturbed mid-transfer
      cpol = 1'b1; cpha = 1'b1; div = 8'd3; cs_sel = 1'b1; tx_data = 8'h3C;
      loop_en = 1'b0; miso_fix = 1'b1;
      repeat (2) tick();
      check("m3_idle_sclk", sclk, 1'b1);
      clear_counts();
      exp_q.push_back(8'hFF);
      do_start();
      check("m3_cs_n", cs_n, 2'b01);
      for (int k = 0; k < 16; k++) begin
         if (k != 0) tick();
         if (k == 5) begin
            div = 8'd0; cs_sel = 1'b0; cpha = 1'b0; tx_data = 8'h00;
         end
         sc[k] = sclk;
      end
      check("m3_sclk_k7", sc[7], 1'b1);
      check("m3_sclk_k8", sc[8], 1'b0);
      check("m3_sclk_k11", sc[11], 1'b0);
      check("m3_sclk_k12", sc[12], 1'b1);
      check("m3_cs_n_mid", cs_n, 2'b01);
      wait_idle(400, ok);
      check("m3_done", 32'(ok), 1);
      check("m3_cs_low_cycles", cs_low_cnt, 72);
      check("m3_cs1_low_cycles", cs1_low_cnt, 72);
      check("m3_sclk_rises", rise_cnt, 8);
      check("m3_rx_pulses", rx_cnt, 1);
      check("m3_sclk_idle_after", sclk, 1'b1);

      // ---- burst: 0x01, then 0x80 with start+release together, then release
      cpol = 1'b0; cpha = 1'b0; div = 8'd1; cs_sel = 1'b0; tx_data = 8'h01;
      hold_cs = 1'b1; loop_en = 1'b1;
      repeat (2) tick();
      clear_counts();
      exp_q.push_back(8'h01);
      do_start();
      hold_cs = 1'b0;
      wait_ready(200, ok);
      check("bst_hold1", 32'(ok), 1);
      repeat (2) tick();
      check("bst_hold1_cs_n", cs_n, 2'b10);
      check("bst_hold1_sclk", sclk, 1'b0);
      check("bst_hold1_ready", ready, 1'b1);
      check("bst_rx1_pulses", rx_cnt, 1);
      tx_data = 8'h80; hold_cs = 1'b1; rel = 1'b1;
      exp_q.push_back(8'h80);
      do_start();
      rel = 1'b0; hold_cs = 1'b0;
      check("bst_w2_cs_n", cs_n, 2'b10);
      check("bst_w2_ready", ready, 1'b0);
      check("bst_w2_mosi_msb", mosi, 1'b1);
      wait_ready(200, ok);
      check("bst_hold2", 32'(ok), 1);
      repeat (2) tick();
      check("bst_rx2_pulses", rx_cnt, 2);
      check("bst_hold2_cs_n", cs_n, 2'b10);
      rel = 1'b1;
      tick();
      rel = 1'b0;
      check("bst_trail0_cs_n", cs_n, 2'b10);
      tick();
      check("bst_trail1_cs_n", cs_n, 2'b10);
      tick();
      check("bst_released_cs_n", cs_n, 2'b11);
      tick();
      check("bst_single_release", cs0_rel_cnt, 1);

      // ---- reset after 5 sclk toggles
      tx_data = 8'hC3; div = 8'd1;
      clear_counts();
      do_start();
      ntog = 0;
      prev = sclk;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (sclk !== prev) ntog++;
         prev = sclk;
      end
      check("abort_toggles", ntog, 5);
      reset = 1'b1;
      tick();
      check("abort_cs_n", cs_n, 2'b11);
      check("abort_sclk", sclk, 1'b0);
      check("abort_rx_valid", rx_valid, 1'b0);
      reset = 1'b0;
      tick();
      check("abort_ready", ready, 1'b1);
      repeat (3) tick();
      check("abort_no_rx", rx_cnt, 0);

      // ---- start during XFER is ignored
      div = 8'd0; tx_data = 8'h5A; cs_sel = 1'b0;
      clear_counts();
      exp_q.push_back(8'h5A);
      do_start();
      repeat (6) tick();
      tx_data = 8'hFF; cs_sel = 1'b1; start = 1'b1;
      repeat (2) tick();
      start = 1'b0; cs_sel = 1'b0;
      wait_idle(200, ok);
      check("ign_done", 32'(ok), 1);
      repeat (10) tick();
      check("ign_rx_pulses", rx_cnt, 1);
      check("ign_cs_low_cycles", cs_low_cnt, 18);
      check("ign_cs1_never_low", cs1_low_cnt, 0);
      check("ign_cs_n_idle", cs_n, 2'b11);

      // ---- out-of-range chip select on the NUM_CS=3 instance
      tx_data = 8'h96; div = 8'd0;
      cs_sel3 = 2'd3; start3 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bad_sel_cs_n3", cs_n3, 3'b111);
         check("bad_sel_ready3", ready3, 1'b1);
      end
      start3 = 1'b0;
      cs_sel3 = 2'd2; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      check("sel2_cs_n3", cs_n3, 3'b011);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (ready3 === 1'b1 && cs_n3 === 3'b111) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("sel2_done", 32'(ok), 1);

      check("cs_onehot", onehot_viol, 0);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
